dram_bist: RTL

DRAM_BIST -- requirements
Module: dram_bist

---
 rtl/dram_bist_pkg.sv | 20 ++
 rtl/dram_bist_if.sv | 22 ++
 rtl/dram_bist_reporter.sv | 64 ++++++
 rtl/dram_bist.sv | 119 +++++++++++
 4 files changed

// File: rtl/dram_bist_pkg.sv
// rtl/dram_bist_pkg.sv - shared state encoding, pattern byte and report characters for dram_bist
package dram_bist_pkg;

    typedef enum logic [3:0] {
        IDLE,
        WAIT_CAL,
        WRITE,
        READ,
        INV_WRITE,
        INV_READ,
        REPORT,
        GAP,
        DONE
    } state_t;

    localparam logic [7:0] PAT_BYTE  = 8'hA5;
    localparam logic [7:0] CHAR_PASS = 8'h50;
    localparam logic [7:0] CHAR_FAIL = 8'h46;

endpackage

// File: rtl/dram_bist_if.sv
// rtl/dram_bist_if.sv - memory request bus between dram_bist (master) and the memory port (slave)
interface dram_bist_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/dram_bist_reporter.sv
// rtl/dram_bist_reporter.sv - sends the three-byte result record over the byte transmitter handshake
module dram_bist_reporter
    import dram_bist_pkg::*;
(
    input  logic        clk,
    input  logic        nrst,
    input  logic        go,
    input  logic [15:0] err_count,
    input  logic        tx_done,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    output logic        done
);

    state_t     state, state_nxt;
    logic [1:0] byte_idx, byte_idx_nxt;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state    <= IDLE;
            byte_idx <= '0;
        end else begin
            state    <= state_nxt;
            byte_idx <= byte_idx_nxt;
        end
    end

    // Byte order: status character, then err_count low byte, then high byte
    always_comb begin
        state_nxt    = state;
        byte_idx_nxt = byte_idx;
        tx_start     = 1'b0;
        tx_data      = '0;
        done         = 1'b0;
        case (state)
            IDLE: begin
                if (go) begin
                    state_nxt    = REPORT;
                    byte_idx_nxt = '0;
                end
            end
            REPORT: begin
                tx_start = 1'b1;
                case (byte_idx)
                    2'd0:    tx_data = (err_count == 16'd0) ? CHAR_PASS : CHAR_FAIL;
                    2'd1:    tx_data = err_count[7:0];
                    default: tx_data = err_count[15:8];
                endcase
                if (tx_done) begin
                    if (byte_idx == 2'd2) begin
                        state_nxt = IDLE;
                        done      = 1'b1;
                    end else begin
                        state_nxt    = GAP;
                        byte_idx_nxt = byte_idx + 2'd1;
                    end
                end
            end
            GAP:     state_nxt = REPORT;
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: rtl/dram_bist.sv
// rtl/dram_bist.sv - DRAM write/read-back self test; DRAM_BIST_INV_PASS_EN adds an inverted-pattern pass
module dram_bist
    import dram_bist_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h0000_0020,
    parameter int                NUM_WORDS   = 16,
    parameter int                ADDR_STRIDE = 4
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        start,
    input  logic        calib_ok,
    dram_bist_if.master mem,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_done,
    output logic        busy,
    output logic        pass,
    output logic        fail,
    output logic [15:0] err_count
);

    state_t            state, state_nxt;
    logic [15:0]       word_idx;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] pat;
    logic [DATA_W-1:0] exp_data;
    logic              last_word;
    logic              is_write;
    logic              is_read;
    logic              inv_pass;
    logic              rep_done;

`ifdef DRAM_BIST_INV_PASS_EN
    assign inv_pass = (state == INV_WRITE) || (state == INV_READ);
    assign is_write = (state == WRITE) || (state == INV_WRITE);
    assign is_read  = (state == READ) || (state == INV_READ);
`else
    assign inv_pass = 1'b0;
    assign is_write = (state == WRITE);
    assign is_read  = (state == READ);
`endif

    assign last_word = (word_idx == 16'(NUM_WORDS - 1));
    assign pat       = DATA_W'(addr) ^ {(DATA_W/8){PAT_BYTE}};
    assign exp_data  = inv_pass ? ~pat : pat;

    always_ff @(posedge clk) begin
        if (!nrst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = WAIT_CAL;
            WAIT_CAL:   if (calib_ok) state_nxt = WRITE;
            WRITE:      if (mem.mem_ready && last_word) state_nxt = READ;
`ifdef DRAM_BIST_INV_PASS_EN
            READ:       if (mem.mem_ready && last_word) state_nxt = INV_WRITE;
            INV_WRITE:  if (mem.mem_ready && last_word) state_nxt = INV_READ;
            INV_READ:   if (mem.mem_ready && last_word) state_nxt = REPORT;
`else
            READ:       if (mem.mem_ready && last_word) state_nxt = REPORT;
`endif
            REPORT:     if (rep_done) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    // Address walks by stride; every pass restarts at BASE_ADDR after its last word
    always_ff @(posedge clk) begin
        if (!nrst) begin
            word_idx  <= '0;
            addr      <= '0;
            err_count <= '0;
        end else begin
            if ((state == IDLE || state == DONE) && start)
                err_count <= '0;
            if (state == WAIT_CAL) begin
                word_idx <= '0;
                addr     <= BASE_ADDR;
            end else if ((is_read || is_write) && mem.mem_ready) begin
                if (last_word) begin
                    word_idx <= '0;
                    addr     <= BASE_ADDR;
                end else begin
                    word_idx <= word_idx + 16'd1;
                    addr     <= addr + ADDR_W'(ADDR_STRIDE);
                end
                if (is_read && (mem.mem_rdata != exp_data) && (err_count != 16'hFFFF))
                    err_count <= err_count + 16'd1;
            end
        end
    end

    assign mem.mem_write = is_write;
    assign mem.mem_read  = is_read;
    assign mem.mem_addr  = (is_read || is_write) ? addr : '0;
    assign mem.mem_wdata = is_write ? exp_data : '0;

    assign busy = (state != IDLE) && (state != DONE);
    assign pass = (state == DONE) && (err_count == 16'd0);
    assign fail = (state == DONE) && (err_count != 16'd0);

    dram_bist_reporter u_reporter (
        .clk       (clk),
        .nrst      (nrst),
        .go        (state == REPORT),
        .err_count (err_count),
        .tx_done   (tx_done),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .done      (rep_done)
    );

endmodule
